// File: rtl/next_pc_ctrl.sv
// next_pc_ctrl: fetch PC register, EX-stage branch resolution and redirect, perf counters.
// Define NEXT_PC_BTB_EN to add a direct-mapped BTB with 2-bit counters; otherwise static not-taken.
module next_pc_ctrl #(
  parameter int XLEN = 32,
  parameter int BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [31:0]     ex_inst,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            BrEq,
  input  logic            BrLt,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  output logic            flush,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispredict_cnt
);
  logic [1:0]      sync_q;
  logic            run;
  logic [XLEN-1:0] pc_q, pc_d, pc_inc, actual_next;
  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic            is_jump, is_br, br_taken, ctrl, taken, mispredict;
  logic [31:0]     branch_q, mispredict_q;

  // Reset asserts asynchronously but releases through two flops; nothing advances until run.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], 1'b1};
  assign run = sync_q[1];

  assign opcode = ex_inst[6:2];
  assign funct3 = ex_inst[14:12];
  assign is_jump = opcode == 5'b11011 || opcode == 5'b11001;
  assign is_br = opcode == 5'b11000;
  assign br_taken = funct3[2] ? (BrLt ^ funct3[0]) : (!funct3[1] && (BrEq ^ funct3[0]));
  assign ctrl = ex_valid && (is_jump || is_br);
  assign taken = is_jump || (is_br && br_taken);
  assign actual_next = taken ? ex_target : ex_pc + XLEN'(4);
  assign mispredict = run && ctrl && (taken != ex_pred_taken || (taken && ex_target != ex_pred_target));
  assign flush = mispredict;
  assign pc_inc = pc_q + XLEN'(4);
  assign pc_d = mispredict ? actual_next : stall ? pc_q : pred_target_f;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q <= RESET_PC;
      branch_q <= '0;
      mispredict_q <= '0;
    end else if (run) begin
      pc_q <= pc_d;
      branch_q <= branch_q + {31'd0, ctrl};
      mispredict_q <= mispredict_q + {31'd0, mispredict};
    end

  assign pc_f = pc_q;
  assign branch_cnt = branch_q;
  assign mispredict_cnt = mispredict_q;

`ifdef NEXT_PC_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
  logic [1:0]             ctr_q [BTB_ENTRIES];
  logic [IDX_W-1:0]       f_idx, e_idx;
  logic [TAG_W-1:0]       f_tag, e_tag;
  logic                   f_hit, e_hit, upd;
  logic [1:0]             e_ctr;

  assign f_idx = pc_q[IDX_W+1:2];
  assign f_tag = pc_q[XLEN-1:IDX_W+2];
  assign e_idx = ex_pc[IDX_W+1:2];
  assign e_tag = ex_pc[XLEN-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && tag_q[f_idx] == f_tag;
  assign e_hit = valid_q[e_idx] && tag_q[e_idx] == e_tag;
  assign e_ctr = ctr_q[e_idx];
  assign pred_taken_f = f_hit && ctr_q[f_idx][1];
  assign pred_target_f = pred_taken_f ? tgt_q[f_idx] : pc_inc;
  assign upd = run && ctrl && (taken || e_hit);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= '0;
    else if (upd && taken) valid_q[e_idx] <= 1'b1;

  // Same-index lookup in this cycle reads the old entry: writes land on the edge.
  always_ff @(posedge clk)
    if (upd) begin
      if (taken) begin
        tag_q[e_idx] <= e_tag;
        tgt_q[e_idx] <= ex_target;
      end
      ctr_q[e_idx] <= !taken ? (e_ctr == 2'b00 ? 2'b00 : e_ctr - 2'd1) :
                      e_hit ? (e_ctr == 2'b11 ? 2'b11 : e_ctr + 2'd1) :
                      is_jump ? 2'b11 : 2'b10;
    end
`else
  assign pred_taken_f = 1'b0;
  assign pred_target_f = pc_inc;
`endif
endmodule

// File: tb/tb_next_pc_ctrl.sv
// tb_next_pc_ctrl: directed scenario tests for next_pc_ctrl; expectations follow NEXT_PC_BTB_EN.
module tb_next_pc_ctrl;
`ifdef NEXT_PC_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif
  localparam logic [31:0] BEQ = 32'h0000_0063, BNE = 32'h0000_1063, JAL = 32'h0000_006F, JALR = 32'h0000_0067;
  localparam logic [31:0] RST = 32'h4000_0000;

  logic clk = 0, rst_n = 0, stall = 0, ex_valid = 0, BrEq = 0, BrLt = 0, ex_pred_taken = 0;
  logic [31:0] ex_inst = 0, ex_pc = 0, ex_target = 0, ex_pred_target = 0;
  logic [31:0] pc_f, pred_target_f, branch_cnt, mispredict_cnt;
  logic pred_taken_f, flush;
  int tests = 0, fails = 0;

  logic [31:0] dec_inst [13] = '{BEQ, BEQ, BNE, BNE, 32'h4063, 32'h5063, 32'h6063, 32'h7063,
                                 32'h2063, 32'h0000_0013, JAL, JALR, 32'h3063};
  logic dec_eq [13]    = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0, 1};
  logic dec_lt [13]    = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
  logic dec_taken [13] = '{1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0};
  logic dec_ctrl [13]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};

  next_pc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_target(ex_target), .BrEq(BrEq), .BrLt(BrLt), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
    .pred_target_f(pred_target_f), .flush(flush), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] inst, pc, tgt, input logic eq, lt, pt, input logic [31:0] ptgt);
    ex_valid = 1; ex_inst = inst; ex_pc = pc; ex_target = tgt;
    BrEq = eq; BrLt = lt; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1 ex_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    tests++; if (pc_f !== RST) begin fails++; $display("FAIL reset_pc: got %h want %h", pc_f, RST); end
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush: got %b want 0", flush); end
    tests++; if (branch_cnt !== 0 || mispredict_cnt !== 0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", branch_cnt, mispredict_cnt); end
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (pc_f !== RST) begin fails++; $display("FAIL sync_hold%0d: got %h want %h", i, pc_f, RST); end
    end
    @(negedge clk);
    tests++; if (pc_f !== 32'h4000_0004) begin fails++; $display("FAIL first_inc: got %h want 40000004", pc_f); end
    @(negedge clk);
    tests++; if (pc_f !== 32'h4000_0008) begin fails++; $display("FAIL second_inc: got %h want 40000008", pc_f); end
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL post_reset_flush: got %b want 0", flush); end
  endtask

  task automatic test_decode;
    stall = 1;
    for (int i = 0; i < 13; i++) begin
      drive(dec_inst[i], 32'h4000_0500, 32'h4000_0600, dec_eq[i], dec_lt[i], dec_taken[i], 32'h4000_0600);
      #1;
      tests++; if (flush !== 1'b0) begin fails++; $display("FAIL decode%0d_right: got flush %b want 0", i, flush); end
      ex_pred_taken = !dec_taken[i];
      #1;
      tests++; if (flush !== dec_ctrl[i]) begin fails++; $display("FAIL decode%0d_wrong: got flush %b want %b", i, flush, dec_ctrl[i]); end
      ex_valid = 0;
      @(negedge clk);
    end
    drive(JAL, 32'h4000_0500, 32'h4000_0600, 0, 0, 1, 32'h4000_0700);
    #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL decode_bad_target: got flush %b want 1", flush); end
    ex_valid = 0;
    @(negedge clk);
    tests++; if (pc_f !== 32'h4000_0008 || branch_cnt !== 0) begin fails++; $display("FAIL decode_no_side_effect: got pc %h cnt %0d want 40000008 0", pc_f, branch_cnt); end
    stall = 0;
  endtask

  task automatic test_loop;
    logic tk;
    drive(BEQ, 32'h4000_0010, RST, 1, 0, 0, 32'h4000_0014);
    #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL loop1_flush: got %b want 1", flush); end
    tick;
    tests++; if (pc_f !== RST) begin fails++; $display("FAIL loop1_pc: got %h want %h", pc_f, RST); end
    for (int it = 2; it <= 5; it++) begin
      repeat (4) tick;
      tk = it < 5;
      tests++; if (pc_f !== 32'h4000_0010) begin fails++; $display("FAIL loop%0d_fetch: got %h want 40000010", it, pc_f); end
      tests++; if (pred_taken_f !== BTB) begin fails++; $display("FAIL loop%0d_pred: got %b want %b", it, pred_taken_f, BTB); end
      tests++; if (pred_target_f !== (BTB ? RST : 32'h4000_0014)) begin fails++; $display("FAIL loop%0d_ptgt: got %h", it, pred_target_f); end
      drive(BEQ, 32'h4000_0010, RST, tk, 0, BTB, BTB ? RST : 32'h4000_0014);
      #1;
      tests++; if (flush !== (tk ? !BTB : BTB)) begin fails++; $display("FAIL loop%0d_flush: got %b want %b", it, flush, tk ? !BTB : BTB); end
      tick;
      tests++; if (pc_f !== (tk ? RST : 32'h4000_0014)) begin fails++; $display("FAIL loop%0d_pc: got %h", it, pc_f); end
    end
    tests++; if (branch_cnt !== 5) begin fails++; $display("FAIL loop_branch_cnt: got %0d want 5", branch_cnt); end
    tests++; if (mispredict_cnt !== (BTB ? 2 : 4)) begin fails++; $display("FAIL loop_mis_cnt: got %0d want %0d", mispredict_cnt, BTB ? 2 : 4); end
  endtask

  task automatic test_bne_miss;
    drive(BNE, 32'h4000_0040, RST, 1, 0, 0, 32'h4000_0044);
    #1;
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL bne_flush: got %b want 0", flush); end
    tick;
    tests++; if (pc_f !== 32'h4000_0018) begin fails++; $display("FAIL bne_pc: got %h want 40000018", pc_f); end
    tests++; if (branch_cnt !== 6 || mispredict_cnt !== (BTB ? 2 : 4)) begin fails++; $display("FAIL bne_cnt: got %0d/%0d", branch_cnt, mispredict_cnt); end
    repeat (10) tick;
    tests++; if (pc_f !== 32'h4000_0040 || pred_taken_f !== 1'b0) begin fails++; $display("FAIL bne_no_alloc: got pc %h pred %b want 40000040 0", pc_f, pred_taken_f); end
  endtask

  task automatic test_stall_redirect;
    stall = 1;
    tick;
    tests++; if (pc_f !== 32'h4000_0040) begin fails++; $display("FAIL stall_hold: got %h want 40000040", pc_f); end
    drive(JAL, 32'h4000_0304, 32'h4000_0080, 0, 0, 0, 32'h4000_0308);
    #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL stall_flush: got %b want 1", flush); end
    tick;
    tests++; if (pc_f !== 32'h4000_0080) begin fails++; $display("FAIL stall_redirect: got %h want 40000080", pc_f); end
    tick;
    tests++; if (pc_f !== 32'h4000_0080) begin fails++; $display("FAIL stall_hold2: got %h want 40000080", pc_f); end
    tests++; if (branch_cnt !== 7 || mispredict_cnt !== (BTB ? 3 : 5)) begin fails++; $display("FAIL stall_cnt: got %0d/%0d", branch_cnt, mispredict_cnt); end
    stall = 0;
  endtask

  task automatic test_jalr_retarget;
    drive(JALR, 32'h4000_0080, 32'h4000_0100, 0, 0, 0, 32'h4000_0084);
    #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL jalr1_flush: got %b want 1", flush); end
    tick;
    tests++; if (pc_f !== 32'h4000_0100) begin fails++; $display("FAIL jalr1_pc: got %h want 40000100", pc_f); end
    drive(JAL, 32'h4000_0204, 32'h4000_0080, 0, 0, 0, 32'h4000_0208);
    tick;
    tests++; if (pc_f !== 32'h4000_0080) begin fails++; $display("FAIL jalr_steer: got %h want 40000080", pc_f); end
    tests++; if (pred_taken_f !== BTB || pred_target_f !== (BTB ? 32'h4000_0100 : 32'h4000_0084)) begin fails++; $display("FAIL jalr2_pred: got %b %h", pred_taken_f, pred_target_f); end
    drive(JALR, 32'h4000_0080, 32'h4000_0200, 0, 0, BTB, BTB ? 32'h4000_0100 : 32'h4000_0084);
    #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL jalr2_flush: got %b want 1", flush); end
    tick;
    tests++; if (pc_f !== 32'h4000_0200) begin fails++; $display("FAIL jalr2_pc: got %h want 40000200", pc_f); end
    drive(JAL, 32'h4000_0204, 32'h4000_0080, 0, 0, 0, 32'h4000_0208);
    tick;
    tests++; if (pred_target_f !== (BTB ? 32'h4000_0200 : 32'h4000_0084)) begin fails++; $display("FAIL jalr_btb_update: got %h", pred_target_f); end
    tests++; if (branch_cnt !== 11 || mispredict_cnt !== (BTB ? 7 : 9)) begin fails++; $display("FAIL jalr_cnt: got %0d/%0d", branch_cnt, mispredict_cnt); end
  endtask

  task automatic test_wrap;
    drive(JAL, 32'h4000_0400, 32'hFFFF_FFFC, 0, 0, 0, 32'h4000_0404);
    tick;
    tests++; if (pc_f !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_redirect: got %h want fffffffc", pc_f); end
    tick;
    tests++; if (pc_f !== 32'h0) begin fails++; $display("FAIL wrap_inc: got %h want 0", pc_f); end
  endtask

  task automatic test_mid_reset;
    drive(BEQ, 32'h4000_0010, RST, 1, 0, 0, 32'h4000_0014);
    #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL midrst_pre_flush: got %b want 1", flush); end
    rst_n = 0;
    #1;
    tests++; if (pc_f !== RST || flush !== 1'b0) begin fails++; $display("FAIL midrst_async: got pc %h flush %b", pc_f, flush); end
    tests++; if (branch_cnt !== 0 || mispredict_cnt !== 0) begin fails++; $display("FAIL midrst_cnt: got %0d/%0d want 0/0", branch_cnt, mispredict_cnt); end
    ex_valid = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (2) tick;
    tests++; if (pc_f !== RST) begin fails++; $display("FAIL midrst_hold: got %h want %h", pc_f, RST); end
    repeat (4) tick;
    tests++; if (pc_f !== 32'h4000_0010 || pred_taken_f !== 1'b0) begin fails++; $display("FAIL midrst_btb_cleared: got pc %h pred %b", pc_f, pred_taken_f); end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_loop;
    test_bne_miss;
    test_stall_redirect;
    test_jalr_retarget;
    test_wrap;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
